cond_exec_unit: RTL

- Sits directly downstream of the ALU in the execute stage.
- Evaluates the 4-bit ARM condition field against the architectural NZCV register and latches the ALU's flags under FlagW control.
- Feeds the stored carry back to the ALU as PrevC.
- Registers the condition-gated write enables into the execute/memory pipeline boundary, with stall and flush handshakes.

---
 rtl/cond_exec_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: execute-stage condition check, NZCV flag register and
// EX/MEM boundary register for the gated write enables.
// Optional feature macro: COND_EXEC_NV_TRAP_EN adds a sticky undef_trap
// output raised by any valid, non-stalled, non-flushed NV instruction.
module cond_exec_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic [3:0] ALUFlags,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       CondEx,
  output logic       PrevC,
  output logic [3:0] Flags,
  output logic       m_valid,
  output logic       m_pc_src,
  output logic       m_reg_write,
  output logic       m_mem_write
`ifdef COND_EXEC_NV_TRAP_EN
  ,
  output logic       undef_trap
`endif
);

  logic n, z, c, v;
  logic go;

  assign {n, z, c, v} = Flags;
  assign PrevC        = Flags[1];
  assign go           = valid_in & CondEx & ~stall & ~flush;

  // Condition decode against the registered flags only (no ALUFlags bypass).
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

  // NZCV register: the two halves are written independently under FlagW.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Flags <= FLAG_RESET;
    end else if (go) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // EX/MEM boundary: flush clears even while stalled; stall otherwise holds.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      m_valid     <= 1'b0;
      m_pc_src    <= 1'b0;
      m_reg_write <= 1'b0;
      m_mem_write <= 1'b0;
    end else if (!stall) begin
      m_valid     <= valid_in;
      m_pc_src    <= go & PCS;
      m_reg_write <= go & RegW & ~NoWrite;
      m_mem_write <= go & MemW;
    end
  end

`ifdef COND_EXEC_NV_TRAP_EN
  // Sticky trap on an NV instruction that actually reaches the boundary.
  always_ff @(posedge clk) begin
    if (!reset_n)
      undef_trap <= 1'b0;
    else if (valid_in && !stall && !flush && Cond == 4'b1111)
      undef_trap <= 1'b1;
  end
`endif

endmodule
